weighted_rr_scheduler: RTL and testbench

WEIGHTED_RR_SCHEDULER -- requirements
Module: weighted_rr_scheduler

---
 rtl/weighted_rr_scheduler_pkg.sv | 17 +
 rtl/weighted_rr_scheduler_if.sv | 29 ++
 rtl/weighted_rr_scheduler_pick.sv | 31 +++
 rtl/weighted_rr_scheduler.sv | 113 +++++++++++
 tb/tb_weighted_rr_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weighted_rr_scheduler_pkg.sv
// Shared types and helpers for the weighted round-robin scheduler.
// Imported by the interface, the picker and the top.
package rr_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/weighted_rr_scheduler_if.sv
// Request/grant bundle between requesters and the scheduler.
// The master drives requests and beat accepts; the slave drives ownership.
interface weighted_rr_scheduler_if
  import rr_sched_pkg::*;
#(
  parameter int request_lines = 4,
  parameter int weight_w      = 4
);

  localparam int IW = idx_w(request_lines);

  logic [request_lines-1:0]          req;
  logic [request_lines*weight_w-1:0] weight;
  logic                              ack;
  logic [request_lines-1:0]          grant;
  logic [IW-1:0]                     grant_idx;
  logic [weight_w-1:0]               credit;

  modport master (
    output req, weight, ack,
    input  grant, grant_idx, credit
  );

  modport slave (
    input  req, weight, ack,
    output grant, grant_idx, credit
  );

endinterface

// File: rtl/weighted_rr_scheduler_pick.sv
// Rotating first-set-bit picker: search begins one past ptr_i
// and wraps, so the previous owner is always considered last.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    int j;
    j        = 0;
    onehot_o = '0;
    idx_o    = '0;
    vld_o    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!vld_o && req_i[j]) begin
        vld_o       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/weighted_rr_scheduler.sv
// Weighted round-robin owner arbitration: each winner holds the
// resource for up to weight[i] accepted beats, then rotates.
module weighted_rr_scheduler
  import rr_sched_pkg::*;
#(
  parameter int request_lines = 4,
  parameter int weight_w      = 4
) (
  input logic clk,
  input logic rst,
  weighted_rr_scheduler_if.slave bus
);

  localparam int N  = request_lines;
  localparam int W  = weight_w;
  localparam int IW = idx_w(N);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  credit_q, credit_d;

  logic [N-1:0]  pick_oh;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic [W-1:0]  w_a [N];
  logic [W-1:0]  load_w;
  logic          own_req;
  logic          beat;
  logic          rel;
  logic          load;

  for (genvar i = 0; i < N; i++) begin : g_w
    assign w_a[i] = bus.weight[i*W +: W];
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .vld_o    (pick_vld)
  );

  assign own_req = bus.req[idx_q];
  assign beat    = (state_q == OWNED)
                 & own_req & bus.ack;
  assign rel     = (state_q == OWNED)
                 & (~own_req
                 | (beat & (credit_q == W'(1))));
  assign load    = ((state_q == IDLE) | rel)
                 & pick_vld;
  assign load_w  = w_a[pick_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= IW'(N - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pick_vld) state_d = OWNED;
      OWNED: if (rel && !pick_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A zero weight still grants one beat.
  always_comb begin
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    unique case (1'b1)
      load: begin
        grant_d  = pick_oh;
        idx_d    = pick_idx;
        ptr_d    = pick_idx;
        credit_d = (load_w == '0) ? W'(1) : load_w;
      end
      (rel & ~pick_vld): begin
        grant_d  = '0;
        idx_d    = '0;
        credit_d = '0;
      end
      (beat & ~rel): begin
        credit_d = credit_q - W'(1);
      end
      default: ;
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.credit    = credit_q;

endmodule

// File: tb/tb_weighted_rr_scheduler.sv
// Directed bench for weighted_rr_scheduler (4 lines, 4-bit weights).
// Each task drives one scenario and checks outputs 1ns after the edge.
module tb_weighted_rr_scheduler;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  weighted_rr_scheduler_if #(
    .request_lines (4),
    .weight_w      (4)
  ) bus ();

  weighted_rr_scheduler #(
    .request_lines (4),
    .weight_w      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(
    input logic [3:0] w0,
    input logic [3:0] w1,
    input logic [3:0] w2,
    input logic [3:0] w3
  );
    bus.weight = {w3, w2, w1, w0};
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    bus.req = '0;
    bus.ack = 1'b0;
    set_w(4'd1, 4'd1, 4'd1, 4'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    bus.req = 4'b1111;
    bus.ack = 1'b1;
    tick();
    n_chk++;
    if (bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_grant got %b want 0000",
               bus.grant);
    end
    n_chk++;
    if (bus.grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_idx got %0d want 0",
               bus.grant_idx);
    end
    n_chk++;
    if (bus.credit !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_credit got %0d want 0",
               bus.credit);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] eg [5];
    logic [1:0] ei [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ei = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus.ack = 1'b1;
    bus.req = 4'b1111;
    #1;
    n_chk++;
    if (bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL rot_no_comb got %b want 0000",
               bus.grant);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++;
      if ({bus.grant, bus.grant_idx, bus.credit}
          !== {eg[k], ei[k], 4'd1}) begin
        n_fail++;
        $display("FAIL rot[%0d] got %b/%0d/%0d want %b/%0d/1",
                 k, bus.grant, bus.grant_idx, bus.credit,
                 eg[k], ei[k]);
      end
    end
  endtask

  task automatic test_weighted();
    logic [3:0] eg [8];
    logic [3:0] ec [8];
    eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0100,
           4'b0100, 4'b0001, 4'b0001, 4'b0001};
    ec = '{4'd3, 4'd2, 4'd1, 4'd2,
           4'd1, 4'd3, 4'd2, 4'd1};
    do_reset();
    set_w(4'd3, 4'd1, 4'd2, 4'd1);
    bus.ack = 1'b1;
    bus.req = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_chk++;
      if ({bus.grant, bus.credit} !== {eg[k], ec[k]}) begin
        n_fail++;
        $display("FAIL wrr[%0d] got %b/%0d want %b/%0d",
                 k, bus.grant, bus.credit, eg[k], ec[k]);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    set_w(4'd1, 4'd5, 4'd1, 4'd6);
    bus.ack = 1'b0;
    bus.req = 4'b0010;
    tick();
    n_chk++;
    if ({bus.grant, bus.credit} !== {4'b0010, 4'd5}) begin
      n_fail++;
      $display("FAIL drop_load got %b/%0d want 0010/5",
               bus.grant, bus.credit);
    end
    bus.ack = 1'b1;
    bus.req = 4'b1010;
    tick();
    tick();
    n_chk++;
    if ({bus.grant, bus.credit} !== {4'b0010, 4'd3}) begin
      n_fail++;
      $display("FAIL drop_hold got %b/%0d want 0010/3",
               bus.grant, bus.credit);
    end
    bus.req = 4'b1000;
    tick();
    n_chk++;
    if ({bus.grant, bus.grant_idx, bus.credit}
        !== {4'b1000, 2'd3, 4'd6}) begin
      n_fail++;
      $display("FAIL drop_move got %b/%0d/%0d want 1000/3/6",
               bus.grant, bus.grant_idx, bus.credit);
    end
  endtask

  task automatic test_sole();
    int bad;
    bad = 0;
    do_reset();
    set_w(4'd1, 4'd1, 4'd0, 4'd1);
    bus.ack = 1'b1;
    bus.req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      tick();
      if ({bus.grant, bus.credit} !== {4'b0100, 4'd1})
        bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sole_regrant got %0d bad cycles want 0",
               bad);
    end
  endtask

  task automatic test_idle_ack_reset();
    int bad;
    bad = 0;
    do_reset();
    set_w(4'd5, 4'd1, 4'd1, 4'd2);
    bus.ack = 1'b1;
    bus.req = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      if ({bus.grant, bus.credit} !== 8'h00) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_ack got %0d bad cycles want 0",
               bad);
    end
    bus.ack = 1'b0;
    bus.req = 4'b0001;
    tick();
    bus.ack = 1'b1;
    tick();
    tick();
    bus.ack = 1'b0;
    n_chk++;
    if ({bus.grant, bus.credit} !== {4'b0001, 4'd3}) begin
      n_fail++;
      $display("FAIL mid_burst got %b/%0d want 0001/3",
               bus.grant, bus.credit);
    end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.grant, bus.grant_idx, bus.credit} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_rst got %b/%0d/%0d want 0/0/0",
               bus.grant, bus.grant_idx, bus.credit);
    end
    bus.req = 4'b1000;
    tick();
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_rst_gap got %b want 0000",
               bus.grant);
    end
    tick();
    n_chk++;
    if ({bus.grant, bus.grant_idx, bus.credit}
        !== {4'b1000, 2'd3, 4'd2}) begin
      n_fail++;
      $display("FAIL post_rst got %b/%0d/%0d want 1000/3/2",
               bus.grant, bus.grant_idx, bus.credit);
    end
  endtask

  task automatic test_no_preempt();
    int bad;
    bad = 0;
    do_reset();
    set_w(4'd4, 4'd1, 4'd1, 4'd1);
    bus.ack = 1'b0;
    bus.req = 4'b1111;
    tick();
    set_w(4'd9, 4'd1, 4'd1, 4'd1);
    for (int k = 0; k < 20; k++) begin
      tick();
      if ({bus.grant, bus.credit} !== {4'b0001, 4'd4})
        bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_preempt got %0d bad cycles want 0",
               bad);
    end
    bus.ack = 1'b1;
    tick();
    n_chk++;
    if ({bus.grant, bus.credit} !== {4'b0001, 4'd3}) begin
      n_fail++;
      $display("FAIL beat_after_hold got %b/%0d want 0001/3",
               bus.grant, bus.credit);
    end
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b0;
    bus.req    = '0;
    bus.ack    = 1'b0;
    bus.weight = '0;
    test_reset();
    test_rotation();
    test_weighted();
    test_drop();
    test_sole();
    test_idle_ack_reset();
    test_no_preempt();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
